down_timer: RTL and testbench
=============================

# down_timer

Loadable down-counting timer with terminal-count detection and optional auto-reload. It is the complement of the team's loadable up-counter: software or a controller FSM loads a period, `dec` ticks consume it, and the block flags expiry with a one-cycle `tc` pulse. Typical use is timeouts, baud or tick dividers, and fixed-length sequencing inside the datapath.

## Interface
- `WIDTH`, default 8: counter and load-value width.
- `clk`  in  1: single clock; all state changes on its rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `data_in`  in  WIDTH: load value (period).
- `ld`  in  1: load `data_in` into `q` and into the internal reload register.
- `dec`  in  1: decrement enable (count tick).
- `auto`  in  1: auto-reload mode select, sampled at the expiring edge.
- `q`  out  WIDTH: current count.
- `zero`  out  1: registered, high when `q == 0`.
- `tc`  out  1: registered one-cycle terminal-count pulse.
- `busy`  out  1: registered, high while state is RUN.

## Operation
- Internal state: `reload` register (WIDTH), FSM with states IDLE, RUN and EXPIRED.
- Priority per edge: `rst` > `ld` > `dec`.
- Reset:
  - `q = 0`, `reload = 0`, `zero = 1`, `tc = 0`, `busy = 0`, state IDLE.
- `ld` in any state:
  - `q <= data_in`, `reload <= data_in`, `tc <= 0`.
  - If `data_in != 0`, go to RUN.
  - If `data_in == 0`, go to IDLE with `zero = 1`.
  - A reload mid-count never produces `tc`.
- IDLE: `dec` ignored; `q` holds 0.
- RUN with `dec = 1`:
  - If `q > 1`: `q <= q - 1`, `tc <= 0`.
  - If `q == 1` and `auto == 0`: `q <= 0`, `tc <= 1`, go to EXPIRED.
  - If `q == 1` and `auto == 1`: `q <= reload`, `tc <= 1`, stay in RUN.
- RUN with `dec = 0`: `q` holds, `tc <= 0`.
- EXPIRED:
  - `q` holds 0 and `dec` is ignored.
  - Leaves only via `ld` or `rst`.
- No underflow: `q` never wraps from 0 to all-ones. Auto-reload is the only upward change other than `ld`.
- `ld` and `dec` in the same cycle: `ld` wins and the tick is dropped.
- `auto` may change at any time. Only its value at the expiring edge matters.
- `zero` always equals the registered `(q == 0)`. `busy` always equals `(state == RUN)`.

## Timing
- Load latency 1: `ld` sampled at edge k gives `q == data_in` and `busy == 1` after edge k.
- Decrement latency 1 per `dec` cycle. There is no throughput limit; `dec` may be held high continuously.
- A load of N with `dec` held high gives `tc` high for exactly one cycle, after the N-th tick edge.
- In auto mode with `reload = N` and `dec` continuously high, `tc` repeats every N cycles.
- With N = 1, `tc` stays high on every tick cycle.
- `rst` at any edge, including mid-count or coincident with `tc`, forces reset values after that edge. Any pending `tc` is suppressed.
- All outputs are registered; there are no combinational input-to-output paths.

## Test plan
- Reset then `dec` for 5 cycles: `q = 0`, `zero = 1`, `busy = 0`, `tc` never asserts.
- `ld` with `data_in = 3`, then `dec` high for 4 cycles, `auto = 0`:
  - `q` goes 3, 2, 1, 0, 0.
  - `tc` is high only in the cycle `q` becomes 0.
  - `busy` falls at the same edge and state ends in EXPIRED.
- `ld` with `data_in = 4`, `auto = 1`, `dec` high for 12 cycles: `q` goes 3, 2, 1, 4, 3, 2, 1, 4, …, and `tc` pulses exactly 3 times, 4 cycles apart.
- `ld` with `data_in = 8`, 2 ticks, then `ld` with `data_in = 5` and `dec` both high: `q = 5` (tick dropped), no `tc`, still `busy`.
- `ld` with `data_in = 0`: `q = 0`, `zero = 1`, `busy = 0`, no `tc`. A following `dec` changes nothing.
- `ld` with `data_in = 0xFF`, `auto = 1`, tick to `q = 1`, then assert `rst` in the same cycle as the final `dec`: `q = 0`, `tc = 0`, `busy = 0`. A later `ld` with `data_in = 2` resumes normal counting.

Source files
------------

// File: rtl/down_timer_if.sv
// Port bundle for the down_timer: load/tick controls in, count and status flags out.
interface down_timer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] data_in;
    logic             ld;
    logic             dec;
    logic             auto;
    logic [WIDTH-1:0] q;
    logic             zero;
    logic             tc;
    logic             busy;

    modport master (
        output data_in, ld, dec, auto,
        input  q, zero, tc, busy
    );

    modport slave (
        input  data_in, ld, dec, auto,
        output q, zero, tc, busy
    );
endinterface

// File: rtl/down_timer.sv
// Loadable down-counting timer with a registered one-cycle terminal-count pulse
// and optional auto-reload from the last loaded period.
module down_timer #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    down_timer_if.slave        bus
);
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUN     = 2'd1,
        S_EXPIRED = 2'd2
    } state_e;

    state_e           state_q,  state_d;
    logic [WIDTH-1:0] count_q,  count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             zero_q,   zero_d;
    logic             tc_q,     tc_d;
    logic             busy_q,   busy_d;

    // Next-state and next-output logic; ld takes priority over dec.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        tc_d     = 1'b0;

        if (bus.ld) begin
            count_d  = bus.data_in;
            reload_d = bus.data_in;
            if (bus.data_in != {WIDTH{1'b0}}) begin
                state_d = S_RUN;
            end else begin
                state_d = S_IDLE;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    count_d = {WIDTH{1'b0}};
                end
                S_RUN: begin
                    if (bus.dec) begin
                        // The else branch also catches a stray 0 so the count can never wrap.
                        if (count_q > WIDTH'(1)) begin
                            count_d = count_q - WIDTH'(1);
                        end else if (bus.auto) begin
                            count_d = reload_q;
                            tc_d    = 1'b1;
                        end else begin
                            count_d = {WIDTH{1'b0}};
                            tc_d    = 1'b1;
                            state_d = S_EXPIRED;
                        end
                    end else begin
                        count_d = count_q;
                    end
                end
                S_EXPIRED: begin
                    count_d = {WIDTH{1'b0}};
                end
                default: begin
                    state_d = S_IDLE;
                    count_d = {WIDTH{1'b0}};
                end
            endcase
        end

        zero_d = (count_d == {WIDTH{1'b0}});
        busy_d = (state_d == S_RUN);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            count_q  <= {WIDTH{1'b0}};
            reload_q <= {WIDTH{1'b0}};
            zero_q   <= 1'b1;
            tc_q     <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            zero_q   <= zero_d;
            tc_q     <= tc_d;
            busy_q   <= busy_d;
        end
    end

    assign bus.q    = count_q;
    assign bus.zero = zero_q;
    assign bus.tc   = tc_q;
    assign bus.busy = busy_q;
endmodule

// File: tb/tb_down_timer.sv
// Directed self-checking bench for down_timer with hand-computed expectations.
module tb_down_timer;
    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   tc_count;

    down_timer_if #(.WIDTH(8)) bus ();

    down_timer #(.WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [7:0] eq, input logic ez,
                              input logic et, input logic eb);
        check({tag, ".q"},    32'(bus.q),    32'(eq));
        check({tag, ".zero"}, 32'(bus.zero), 32'(ez));
        check({tag, ".tc"},   32'(bus.tc),   32'(et));
        check({tag, ".busy"}, 32'(bus.busy), 32'(eb));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst         = 1'b1;
        bus.data_in = 8'd0;
        bus.ld      = 1'b0;
        bus.dec     = 1'b0;
        bus.auto    = 1'b0;
        step();
        check_outs("reset", 8'd0, 1'b1, 1'b0, 1'b0);

        // dec while idle does nothing
        rst     = 1'b0;
        bus.dec = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check_outs("idle_dec", 8'd0, 1'b1, 1'b0, 1'b0);
        end

        // load 3, single-shot expiry
        bus.dec     = 1'b0;
        bus.ld      = 1'b1;
        bus.data_in = 8'd3;
        step();
        check_outs("ld3", 8'd3, 1'b0, 1'b0, 1'b1);
        bus.ld  = 1'b0;
        bus.dec = 1'b1;
        step();
        check_outs("ld3_t1", 8'd2, 1'b0, 1'b0, 1'b1);
        step();
        check_outs("ld3_t2", 8'd1, 1'b0, 1'b0, 1'b1);
        step();
        check_outs("ld3_t3", 8'd0, 1'b1, 1'b1, 1'b0);
        step();
        check_outs("ld3_t4", 8'd0, 1'b1, 1'b0, 1'b0);

        // load 4 in auto mode, 12 ticks
        bus.dec     = 1'b0;
        bus.auto    = 1'b1;
        bus.ld      = 1'b1;
        bus.data_in = 8'd4;
        step();
        check_outs("ld4", 8'd4, 1'b0, 1'b0, 1'b1);
        bus.ld   = 1'b0;
        bus.dec  = 1'b1;
        tc_count = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            check_outs("auto4", 8'(4 - ((i + 1) % 4)), 1'b0, ((i + 1) % 4) == 0, 1'b1);
            if (bus.tc) tc_count++;
        end
        check("auto4_tc_count", 32'(tc_count), 32'd3);

        // reload mid-count with coincident dec
        bus.auto    = 1'b0;
        bus.dec     = 1'b0;
        bus.ld      = 1'b1;
        bus.data_in = 8'd8;
        step();
        check_outs("ld8", 8'd8, 1'b0, 1'b0, 1'b1);
        bus.ld  = 1'b0;
        bus.dec = 1'b1;
        step();
        check_outs("ld8_t1", 8'd7, 1'b0, 1'b0, 1'b1);
        step();
        check_outs("ld8_t2", 8'd6, 1'b0, 1'b0, 1'b1);
        bus.ld      = 1'b1;
        bus.data_in = 8'd5;
        step();
        check_outs("reld5", 8'd5, 1'b0, 1'b0, 1'b1);

        // load zero
        bus.dec     = 1'b0;
        bus.data_in = 8'd0;
        step();
        check_outs("ld0", 8'd0, 1'b1, 1'b0, 1'b0);
        bus.ld  = 1'b0;
        bus.dec = 1'b1;
        step();
        check_outs("ld0_dec", 8'd0, 1'b1, 1'b0, 1'b0);

        // load 0xFF in auto mode, tick to 1, reset on the expiring tick
        bus.dec     = 1'b0;
        bus.auto    = 1'b1;
        bus.ld      = 1'b1;
        bus.data_in = 8'hFF;
        step();
        check_outs("ldff", 8'hFF, 1'b0, 1'b0, 1'b1);
        bus.ld  = 1'b0;
        bus.dec = 1'b1;
        for (int i = 0; i < 254; i++) begin
            step();
        end
        check_outs("ldff_at1", 8'd1, 1'b0, 1'b0, 1'b1);
        rst = 1'b1;
        step();
        check_outs("rst_on_tc", 8'd0, 1'b1, 1'b0, 1'b0);

        // resume after reset
        rst         = 1'b0;
        bus.dec     = 1'b0;
        bus.auto    = 1'b0;
        bus.ld      = 1'b1;
        bus.data_in = 8'd2;
        step();
        check_outs("ld2", 8'd2, 1'b0, 1'b0, 1'b1);
        bus.ld  = 1'b0;
        bus.dec = 1'b1;
        step();
        check_outs("ld2_t1", 8'd1, 1'b0, 1'b0, 1'b1);
        step();
        check_outs("ld2_t2", 8'd0, 1'b1, 1'b1, 1'b0);
        step();
        check_outs("ld2_t3", 8'd0, 1'b1, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
